// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/bubble sequencer.
package pipe_stall_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_DIV_BUSY = 1'b1
  } state_e;

  localparam int unsigned DIV_LAT_DFLT = 32;
  localparam int unsigned CNT_W_DFLT   = 6;
  localparam int unsigned INSTR_W      = 32;

  // Instruction word loaded into IF/ID or ID/EXE on flush/bubble (sll $0,$0,0)
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_exe_bubble;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_busy_counter.sv
// Load/decrement counter with zero flag for multi-cycle unit occupancy.
module pipe_busy_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/bubble sequencer for the 5-stage pipeline with divider occupancy tracking.
// Define STALL_PERF_EN to build the stall-cycle performance counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DFLT,
  parameter int unsigned CNT_W   = CNT_W_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_lw_conf,
  input  logic        id_is_div,
  input  logic        id_uses_hilo,
  input  logic        div_done,
  input  logic        flush_all,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_exe_bubble,
  output logic        div_start,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles
);

  state_e     state_q;
  state_e     state_d;
  logic       busy_c;
  logic       hz_c;
  logic       start_c;
  logic       cnt_zero;
  pipe_ctrl_t ctrl_c;

  assign busy_c  = (state_q == ST_DIV_BUSY);
  assign hz_c    = id_lw_conf | (busy_c & (id_is_div | id_uses_hilo));
  assign start_c = ~busy_c & id_is_div & ~hz_c & ~flush_all;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus combinational pipeline controls
  always_comb begin
    state_d   = state_q;
    ctrl_c    = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0, id_exe_bubble: 1'b0};
    div_start = 1'b0;
    mdu_busy  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (start_c) state_d = ST_DIV_BUSY;
      end
      ST_DIV_BUSY: begin
        if (cnt_zero || div_done) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (hz_c) begin
      ctrl_c.pc_we         = 1'b0;
      ctrl_c.if_id_we      = 1'b0;
      ctrl_c.id_exe_bubble = 1'b1;
    end
    // Redirect kills both registers and lets fetch proceed regardless of hazards
    if (flush_all) begin
      ctrl_c = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1, id_exe_bubble: 1'b1};
    end
    div_start = start_c;
    mdu_busy  = busy_c;

    if (!rst_n) begin
      ctrl_c    = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1, id_exe_bubble: 1'b1};
      div_start = 1'b0;
      mdu_busy  = 1'b0;
    end
  end

  assign pc_we         = ctrl_c.pc_we;
  assign if_id_we      = ctrl_c.if_id_we;
  assign if_id_flush   = ctrl_c.if_id_flush;
  assign id_exe_bubble = ctrl_c.id_exe_bubble;

  // Counter holds remaining busy cycles minus one; zero marks the last busy cycle
  pipe_busy_counter #(
    .CNT_W (CNT_W)
  ) u_div_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start_c),
    .load_val_i (CNT_W'(DIV_LAT - 1)),
    .dec_i      (busy_c),
    .zero_o     (cnt_zero)
  );

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (hz_c && !flush_all) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed hazard scenarios plus random traffic.
module tb_pipe_stall_ctrl;

  localparam int unsigned L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_lw_conf = 1'b0;
  logic        id_is_div = 1'b0;
  logic        id_uses_hilo = 1'b0;
  logic        div_done = 1'b0;
  logic        flush_all = 1'b0;
  logic        pc_we;
  logic        if_id_we;
  logic        if_id_flush;
  logic        id_exe_bubble;
  logic        div_start;
  logic        mdu_busy;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .DIV_LAT (L),
    .CNT_W   (6)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_lw_conf    (id_lw_conf),
    .id_is_div     (id_is_div),
    .id_uses_hilo  (id_uses_hilo),
    .div_done      (div_done),
    .flush_all     (flush_all),
    .pc_we         (pc_we),
    .if_id_we      (if_id_we),
    .if_id_flush   (if_id_flush),
    .id_exe_bubble (id_exe_bubble),
    .div_start     (div_start),
    .mdu_busy      (mdu_busy),
    .stall_cycles  (stall_cycles)
  );

  typedef struct packed {
    logic        pc_we;
    logic        if_id_we;
    logic        if_id_flush;
    logic        id_exe_bubble;
    logic        div_start;
    logic        mdu_busy;
    logic [31:0] stall;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          starts[$];

  // Reference model: divider occupancy as "busy cycles still to come"
  int          busy_left = 0;
  logic [31:0] perf_m    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic lw, input logic dv, input logic hl,
                      input logic dn, input logic fl);
    exp_t e;
    logic busy, hz, start;
    @(posedge clk);
    #1;
    rst_n = r; id_lw_conf = lw; id_is_div = dv; id_uses_hilo = hl;
    div_done = dn; flush_all = fl;
    busy  = (busy_left > 0);
    hz    = lw || (busy && (dv || hl));
    start = !busy && dv && !hz && !fl;
    e.stall = perf_m;
`ifndef STALL_PERF_EN
    e.stall = 32'd0;
`endif
    if (!r) begin
      e.pc_we = 1'b0; e.if_id_we = 1'b0; e.if_id_flush = 1'b1; e.id_exe_bubble = 1'b1;
      e.div_start = 1'b0; e.mdu_busy = 1'b0;
      busy_left = 0;
      perf_m = '0;
    end else begin
      if (fl) begin
        e.pc_we = 1'b1; e.if_id_we = 1'b1; e.if_id_flush = 1'b1; e.id_exe_bubble = 1'b1;
      end else begin
        e.pc_we = !hz; e.if_id_we = !hz; e.if_id_flush = 1'b0; e.id_exe_bubble = hz;
      end
      e.div_start = start;
      e.mdu_busy  = busy;
      if (hz && !fl) perf_m = perf_m + 32'd1;
      if (start) busy_left = L;
      else if (busy) busy_left = dn ? 0 : busy_left - 1;
    end
    sb_q.push_back(e);
  endtask

  // Monitor: compares every presented cycle against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_we",         32'(pc_we),         32'(e.pc_we));
        chk("if_id_we",      32'(if_id_we),      32'(e.if_id_we));
        chk("if_id_flush",   32'(if_id_flush),   32'(e.if_id_flush));
        chk("id_exe_bubble", 32'(id_exe_bubble), 32'(e.id_exe_bubble));
        chk("div_start",     32'(div_start),     32'(e.div_start));
        chk("mdu_busy",      32'(mdu_busy),      32'(e.mdu_busy));
        chk("stall_cycles",  stall_cycles,       e.stall);
        if (div_start === 1'b1) starts.push_back(cyc);
      end
    end
  end

  initial begin
    int gap;
    // Reset held three cycles, then release
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Load-use for two cycles, with a DIV sitting in ID
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // DIV then MFLO waiting through full latency
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (L + 2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Early completion on third busy cycle
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Back-to-back DIV: second launch exactly L+1 cycles after the first
    @(negedge clk);
    starts.delete();
    repeat (L + 2) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (L + 1) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    gap = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
    chk("b2b_start_count", 32'(starts.size()), 32'd2);
    chk("b2b_start_gap",   32'(gap),           32'(L + 1));
    // Flush during busy with a HI/LO reader waiting
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (L) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Reset in the middle of a division
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Random traffic with sparse resets and flushes
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) != 0),
           ($urandom_range(5) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(2) == 0),
           ($urandom_range(7) == 0),
           ($urandom_range(11) == 0));
    end
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
